if_else_share_sched: RTL

//  Round-robin scheduler that shares one if_else_self_gen evaluation unit (if-branch, else-branch,

---
 rtl/if_else_share_sched_if.sv | 36 +++
 rtl/if_else_share_sched.sv | 115 +++++++++++
 2 files changed

// File: rtl/if_else_share_sched_if.sv
// rtl/if_else_share_sched_if.sv - requester, unit and response bus of the shared if/else scheduler
interface if_else_share_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_input_bit;
   logic [NUM_REQ*DATA_W-1:0] req_if_data;
   logic [NUM_REQ*DATA_W-1:0] req_else_data;
   logic [DATA_W-1:0]         unit_input_bit;
   logic [DATA_W-1:0]         unit_if_data;
   logic [DATA_W-1:0]         unit_else_data;
   logic [DATA_W-1:0]         unit_result;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [DATA_W-1:0]         rsp_data;
   logic [ID_W-1:0]           rsp_id;
   logic                      busy;
   logic [15:0]               done_count;

   // requester / unit / consumer side
   modport master (
      output req_valid, req_input_bit, req_if_data, req_else_data, unit_result, rsp_ready,
      input  req_ready, unit_input_bit, unit_if_data, unit_else_data,
             rsp_valid, rsp_data, rsp_id, busy, done_count
   );

   // scheduler side
   modport slave (
      input  req_valid, req_input_bit, req_if_data, req_else_data, unit_result, rsp_ready,
      output req_ready, unit_input_bit, unit_if_data, unit_else_data,
             rsp_valid, rsp_data, rsp_id, busy, done_count
   );
endinterface

// File: rtl/if_else_share_sched.sv
// rtl/if_else_share_sched.sv - round-robin scheduler sharing one if/else evaluation unit
module if_else_share_sched #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 32,
   parameter int UNIT_LAT = 2,
   parameter int ID_W     = 2
) (
   input logic                clk,
   input logic                reset,
   if_else_share_sched_if.slave bus
);
   localparam int CNT_W = (UNIT_LAT < 2) ? 1 : $clog2(UNIT_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]  wait_cnt;
   logic [DATA_W-1:0] unit_ib_q;
   logic [DATA_W-1:0] unit_if_q;
   logic [DATA_W-1:0] unit_else_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [ID_W-1:0]   rsp_id_q;
   logic              busy_q;
   logic [15:0]       done_cnt;

   logic              grant_any;
   logic [ID_W-1:0]   grant_id;
   logic [ID_W-1:0]   scan_id;
   logic [ID_W-1:0]   next_ptr;

   // first pending requester at or after rr_ptr, wrapping around NUM_REQ
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      scan_id   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_id = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!grant_any && bus.req_valid[scan_id]) begin
            grant_any = 1'b1;
            grant_id  = scan_id;
         end
      end
   end

   assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

   // grant only while idle and out of reset, so accept is exactly valid & ready in IDLE
   assign bus.req_ready = (state == S_IDLE && !reset && grant_any)
                          ? (NUM_REQ'(1) << grant_id) : '0;

   assign bus.unit_input_bit = unit_ib_q;
   assign bus.unit_if_data   = unit_if_q;
   assign bus.unit_else_data = unit_else_q;
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.rsp_data       = rsp_data_q;
   assign bus.rsp_id         = rsp_id_q;
   assign bus.busy           = busy_q;
   assign bus.done_count     = done_cnt;

   // scheduler FSM: accept, hold operands for UNIT_LAT cycles, present response until taken
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         rr_ptr      <= '0;
         wait_cnt    <= '0;
         unit_ib_q   <= '0;
         unit_if_q   <= '0;
         unit_else_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         busy_q      <= 1'b0;
         done_cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  unit_ib_q   <= bus.req_input_bit[grant_id*DATA_W +: DATA_W];
                  unit_if_q   <= bus.req_if_data[grant_id*DATA_W +: DATA_W];
                  unit_else_q <= bus.req_else_data[grant_id*DATA_W +: DATA_W];
                  rsp_id_q    <= grant_id;
                  wait_cnt    <= CNT_W'(UNIT_LAT);
                  busy_q      <= 1'b1;
                  rr_ptr      <= next_ptr;
                  state       <= S_WAIT;
               end
            end
            S_WAIT: begin
               // last wait cycle: the unit output now reflects the held operands
               if (wait_cnt == CNT_W'(1)) begin
                  rsp_data_q  <= bus.unit_result;
                  rsp_valid_q <= 1'b1;
                  state       <= S_RESP;
               end
               wait_cnt <= wait_cnt - CNT_W'(1);
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_cnt    <= done_cnt + 16'd1;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
